exception_ctrl: RTL and testbench
=================================

# exception_ctrl

Sequential exception/interrupt controller for the single-cycle LEGv8 core; sits beside the main decoder and the ALU decoder in the control path. It arbitrates N external interrupt lines plus the decoder's invalid-opcode flag, raises `Exc` toward the datapath, and holds `EStatus` for the handler. It completes a four-phase handshake with each interrupting device and decodes ERET to leave the handler.

## Interface
- `N_IRQ`, 4: number of external interrupt channels, legal range 1..8.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `instr` input 11: opcode field of the current instruction; ERET decoded as `11'b11010110100`.
- `invalid_op` input 1: main decoder flags the current opcode as unsupported.
- `ExtlRQ` input N_IRQ: level interrupt requests; a device holds its line until it sees its ack.
- `ExcAck` input 1: datapath has redirected the PC to the vector and saved the ELR.
- `Exc` output 1: exception request to the datapath (registered).
- `EStatus` output 4: cause code (registered).
- `ERet` output 1: return-from-exception strobe to the datapath (combinational).
- `ExtlAck` output N_IRQ: per-channel acknowledge (registered).
- `exc_count` output 8: taken-exception counter; present only with `EXC_COUNT_EN`.

## Operation
- States: IDLE, PENDING, HANDLER.
- Cause codes:
  - `4'h0`: none.
  - `4'h1`: invalid opcode.
  - `4'h2`: ERET outside the handler.
  - `4'h8+k`: external channel k.
  - `4'hF`: double fault.
- Eligible channel k: `ExtlRQ[k]=1` and `ExtlAck[k]=0`.
- Priority: invalid_op > ERET-in-IDLE > lowest-index eligible channel.
- IDLE:
  - Any cause present → PENDING; `Exc`←1; `EStatus`←code; winning channel index latched.
  - ERET with no handler active: cause `4'h2`, `ERet` stays 0.
- PENDING:
  - `Exc` and `EStatus` held until `ExcAck`=1 is sampled.
  - Then: → HANDLER; `Exc`←0; if the cause was external, `ExtlAck[k]`←1.
  - Requests and invalid_op are ignored while in PENDING.
- HANDLER:
  - No nesting; external requests stay pending.
  - `EStatus` held for the handler to read.
  - `instr`==ERET: `ERet`=1 in that cycle; next state IDLE; `EStatus`←0.
  - invalid_op in HANDLER: → PENDING; `EStatus`←`4'hF`; `Exc`←1.
  - invalid_op and ERET in the same cycle: double fault wins, `ERet`=0.
- Ack handshake, per channel and independent of state:
  - `ExtlAck[k]` stays 1 until `ExtlRQ[k]`=0 is sampled.
  - It clears on the following edge.
  - Channel k cannot win arbitration again until its ack is 0.
- `ExcAck` outside PENDING is ignored.

## Timing
- Reset values, applied immediately on `reset`=0:
  - state IDLE.
  - `Exc`=0, `EStatus`=0, `ExtlAck`=0, `exc_count`=0.
  - `ERet` is combinationally 0 because the state is IDLE.
- Reset mid-handshake drops every ack and the latched cause; devices re-request.
- Request-to-`Exc` latency: 1 cycle (cause sampled at edge n, `Exc`=1 after edge n).
- `ExcAck` to `Exc`=0 and `ExtlAck[k]`=1: 1 cycle.
- ERET cycle to IDLE: 1 cycle. A request present in the cycle after ERET raises `Exc` one cycle later, so the minimum gap between exceptions is 2 cycles.
- `ExtlRQ[k]` low to `ExtlAck[k]` low: 1 cycle.

## Configuration
- `EXC_COUNT_EN` defined:
  - Adds the `exc_count` port.
  - Counter increments on every PENDING→HANDLER transition.
  - Saturates at 255 and never wraps.
  - Reset to 0.
- `EXC_COUNT_EN` undefined: no port and no counter flops; all other behaviour is identical.

## Test plan
- External interrupt, N_IRQ=4:
  - Stimulus: `ExtlRQ`=4'b0100; `ExcAck` pulsed 3 cycles later; ERET 5 cycles later; `ExtlRQ[2]` dropped afterwards.
  - Required: `Exc`=1 with `EStatus`=4'hA one cycle after the request.
  - `Exc`=0 and `ExtlAck`=4'b0100 one cycle after `ExcAck`.
  - `ERet`=1 in the ERET cycle.
  - `ExtlAck[2]`=0 one cycle after `ExtlRQ[2]` drops.
- Priority: `invalid_op`=1 together with `ExtlRQ`=4'b0011 → `EStatus`=4'h1. After ERET, the next exception shows `EStatus`=4'h8.
- Double fault: invalid_op in HANDLER → `EStatus`=4'hF, `Exc`=1. In the same cycle as ERET → `ERet`=0.
- Stuck device: `ExtlRQ[1]` held high after its ack and after ERET → no new exception from channel 1 while `ExtlAck[1]`=1.
- Async reset while in PENDING with `ExtlAck[0]`=1 → all outputs 0 immediately; IDLE after reset is released.
- `EXC_COUNT_EN`: 300 serviced exceptions → `exc_count`=255. Build without the macro → elaborates with no `exc_count` port.

Source files
------------

// File: rtl/exception_ctrl.sv
// exception_ctrl: exception/interrupt controller for the single-cycle LEGv8 core.
// Arbitrates N_IRQ level interrupt lines plus the decoder's invalid-opcode flag,
// raises Exc toward the datapath, holds the EStatus cause code for the handler,
// runs a four-phase ack handshake per device and decodes ERET to leave the handler.
// Ports: clk, reset (async active-low), instr (opcode field), invalid_op, ExtlRQ[N_IRQ],
//        ExcAck -> Exc, EStatus[3:0], ERet (combinational), ExtlAck[N_IRQ],
//        exc_count[7:0] (only when EXC_COUNT_EN is defined: saturating taken-exception count).
module exception_ctrl #(
  parameter int N_IRQ = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      instr,
  input  logic             invalid_op,
  input  logic [N_IRQ-1:0] ExtlRQ,
  input  logic             ExcAck,
  output logic             Exc,
  output logic [3:0]       EStatus,
  output logic             ERet,
  output logic [N_IRQ-1:0] ExtlAck
`ifdef EXC_COUNT_EN
  ,
  output logic [7:0]       exc_count
`endif
);
  localparam logic [10:0] ERET_OP = 11'b11010110100;
  typedef enum logic [1:0] {IDLE, PENDING, HANDLER} state_t;
  state_t           r_state;
  logic             r_exc;
  logic             r_ext;
  logic [3:0]       r_estatus;
  logic [2:0]       r_chan;
  logic [N_IRQ-1:0] r_ack;
  logic [N_IRQ-1:0] w_elig;
  logic [N_IRQ-1:0] w_set;
  logic [2:0]       w_idx;
  logic             w_eret;
  logic             w_any;
  logic             w_take;
  assign w_eret  = instr == ERET_OP;
  assign w_elig  = ExtlRQ & ~r_ack;
  assign w_any   = |w_elig;
  assign w_take  = r_state == PENDING && ExcAck;
  assign ERet    = r_state == HANDLER && w_eret && !invalid_op;
  assign Exc     = r_exc;
  assign EStatus = r_estatus;
  assign ExtlAck = r_ack;
  // Descending scan leaves the lowest eligible index; w_set acks the latched
  // channel when an external cause is taken. r_ext is kept separately because
  // code 4'hF is shared by channel 7 and the double fault.
  always_comb begin
    w_idx = '0;
    w_set = '0;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      if (w_elig[k]) w_idx = 3'(k);
      w_set[k] = w_take && r_ext && r_chan == 3'(k);
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_exc     <= 1'b0;
      r_ext     <= 1'b0;
      r_estatus <= 4'h0;
      r_chan    <= 3'd0;
      r_ack     <= '0;
    end else begin
      // An ack holds until its device drops the request, independent of state.
      r_ack <= (r_ack & ExtlRQ) | w_set;
      case (r_state)
        IDLE: if (invalid_op || w_eret || w_any) begin
          r_state   <= PENDING;
          r_exc     <= 1'b1;
          r_estatus <= invalid_op ? 4'h1 : w_eret ? 4'h2 : {1'b1, w_idx};
          r_ext     <= !invalid_op && !w_eret;
          r_chan    <= w_idx;
        end
        PENDING: if (ExcAck) begin
          r_state <= HANDLER;
          r_exc   <= 1'b0;
        end
        HANDLER: if (invalid_op) begin
          r_state   <= PENDING;
          r_exc     <= 1'b1;
          r_estatus <= 4'hF;
          r_ext     <= 1'b0;
        end else if (w_eret) begin
          r_state   <= IDLE;
          r_estatus <= 4'h0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef EXC_COUNT_EN
  logic [7:0] r_count;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_count <= 8'd0;
    else if (w_take && r_count != 8'hFF) r_count <= r_count + 8'd1;
  end
  assign exc_count = r_count;
`endif
endmodule

// File: tb/tb_exception_ctrl.sv
// tb_exception_ctrl: randomized + directed bench for exception_ctrl against a behavioural model.
module tb_exception_ctrl;
  localparam int N = 4;
  localparam logic [10:0] ERET_OP = 11'b11010110100;
  logic         clk;
  logic         reset;
  logic [10:0]  instr;
  logic         invalid_op;
  logic [N-1:0] ExtlRQ;
  logic         ExcAck;
  logic         Exc;
  logic [3:0]   EStatus;
  logic         ERet;
  logic [N-1:0] ExtlAck;
`ifdef EXC_COUNT_EN
  logic [7:0]   exc_count;
`endif
  int n_checks = 0;
  int n_errors = 0;
  exception_ctrl #(.N_IRQ(N)) dut (
    .clk(clk), .reset(reset), .instr(instr), .invalid_op(invalid_op),
    .ExtlRQ(ExtlRQ), .ExcAck(ExcAck), .Exc(Exc), .EStatus(EStatus),
    .ERet(ERet), .ExtlAck(ExtlAck)
`ifdef EXC_COUNT_EN
    , .exc_count(exc_count)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  // Behavioural model: mode 0 = idle, 1 = exception requested, 2 = in handler.
  int           m_mode;
  int           m_chan;
  bit           m_ext;
  logic [3:0]   m_code;
  logic [N-1:0] m_ack;
  int           m_cnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode <= 0; m_chan <= 0; m_ext <= 0; m_code <= 4'h0; m_ack <= '0; m_cnt <= 0;
    end else begin
      automatic int win = -1;
      automatic logic [N-1:0] nack = m_ack & ExtlRQ;
      for (int k = 0; k < N; k++) if (win < 0 && ExtlRQ[k] && !m_ack[k]) win = k;
      if (m_mode == 0) begin
        if (invalid_op) begin m_mode <= 1; m_code <= 4'h1; m_ext <= 0; end
        else if (instr == ERET_OP) begin m_mode <= 1; m_code <= 4'h2; m_ext <= 0; end
        else if (win >= 0) begin m_mode <= 1; m_code <= 4'(8 + win); m_ext <= 1; m_chan <= win; end
      end else if (m_mode == 1) begin
        if (ExcAck) begin
          m_mode <= 2;
          if (m_ext) nack[m_chan] = 1'b1;
          m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
        end
      end else begin
        if (invalid_op) begin m_mode <= 1; m_code <= 4'hF; m_ext <= 0; end
        else if (instr == ERET_OP) begin m_mode <= 0; m_code <= 4'h0; end
      end
      m_ack <= nack;
    end
  end
  always @(negedge clk) if (reset) begin
    chk("model_Exc", 8'(Exc), 8'(m_mode == 1));
    chk("model_EStatus", 8'(EStatus), 8'(m_code));
    chk("model_ExtlAck", 8'(ExtlAck), 8'(m_ack));
    chk("model_ERet", 8'(ERet), 8'(m_mode == 2 && instr == ERET_OP && !invalid_op));
`ifdef EXC_COUNT_EN
    chk("model_exc_count", exc_count, 8'(m_cnt));
`endif
  end
  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic service_ack();
    ExcAck = 1'b1; cyc(); ExcAck = 1'b0;
  endtask
  task automatic eret();
    instr = ERET_OP; cyc(); instr = 11'h0;
  endtask
  initial begin
    reset = 1'b0; instr = 11'h0; invalid_op = 1'b0; ExtlRQ = '0; ExcAck = 1'b0;
    cyc();
    chk("reset_Exc", 8'(Exc), 8'd0);
    chk("reset_EStatus", 8'(EStatus), 8'd0);
    chk("reset_ExtlAck", 8'(ExtlAck), 8'd0);
    cyc();
    reset = 1'b1;
    cyc();
    // External interrupt on channel 2
    ExtlRQ = 4'b0100; cyc();
    chk("ext_Exc", 8'(Exc), 8'd1);
    chk("ext_EStatus", 8'(EStatus), 8'hA);
    cyc(2);
    service_ack();
    chk("ack_Exc", 8'(Exc), 8'd0);
    chk("ack_ExtlAck", 8'(ExtlAck), 8'b0100);
    cyc(4);
    instr = ERET_OP; #1;
    chk("eret_ERet", 8'(ERet), 8'd1);
    cyc(); instr = 11'h0;
    chk("eret_EStatus", 8'(EStatus), 8'h0);
    cyc();
    chk("held_rq_no_exc", 8'(Exc), 8'd0);
    ExtlRQ = 4'b0000; cyc();
    chk("drop_ExtlAck", 8'(ExtlAck), 8'd0);
    // Priority: invalid opcode beats channels, then lowest channel
    invalid_op = 1'b1; ExtlRQ = 4'b0011; cyc(); invalid_op = 1'b0;
    chk("prio_EStatus", 8'(EStatus), 8'h1);
    service_ack();
    eret();
    cyc();
    chk("prio_next_Exc", 8'(Exc), 8'd1);
    chk("prio_next_EStatus", 8'(EStatus), 8'h8);
    service_ack();
    chk("prio_ack", 8'(ExtlAck), 8'b0001);
    // Double fault together with ERET
    invalid_op = 1'b1; instr = ERET_OP; #1;
    chk("df_ERet", 8'(ERet), 8'd0);
    cyc(); invalid_op = 1'b0; instr = 11'h0;
    chk("df_Exc", 8'(Exc), 8'd1);
    chk("df_EStatus", 8'(EStatus), 8'hF);
    ExtlRQ = 4'b0000;
    service_ack();
    eret();
    cyc();
    // Stuck device on channel 1
    ExtlRQ = 4'b0010; cyc();
    chk("stuck_EStatus", 8'(EStatus), 8'h9);
    service_ack();
    eret();
    cyc(3);
    chk("stuck_no_exc", 8'(Exc), 8'd0);
    chk("stuck_ack", 8'(ExtlAck), 8'b0010);
    // Async reset in PENDING with channel 0 acked
    ExtlRQ = 4'b0011; cyc();
    service_ack();
    eret();
    invalid_op = 1'b1; cyc(); invalid_op = 1'b0;
    chk("pre_rst_Exc", 8'(Exc), 8'd1);
    chk("pre_rst_ack", 8'(ExtlAck), 8'b0011);
    #1 reset = 1'b0;
    #1;
    chk("arst_Exc", 8'(Exc), 8'd0);
    chk("arst_EStatus", 8'(EStatus), 8'd0);
    chk("arst_ExtlAck", 8'(ExtlAck), 8'd0);
    chk("arst_ERet", 8'(ERet), 8'd0);
    #1 reset = 1'b1; ExtlRQ = '0;
    cyc(2);
    chk("post_rst_idle", 8'(Exc), 8'd0);
    // Randomized traffic checked against the model every cycle
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 4) == 0) ExtlRQ = N'($urandom);
      invalid_op = $urandom_range(0, 19) == 0;
      ExcAck = $urandom_range(0, 1) == 1;
      instr = ($urandom_range(0, 3) == 0) ? ERET_OP : 11'($urandom);
      cyc();
    end
    invalid_op = 1'b0; ExcAck = 1'b0; instr = 11'h0; ExtlRQ = '0;
    cyc(2);
    // 300 serviced exceptions to exercise counter saturation
    for (int i = 0; i < 300; i++) begin
      invalid_op = 1'b1; cyc(); invalid_op = 1'b0;
      service_ack();
      eret();
    end
    cyc();
`ifdef EXC_COUNT_EN
    chk("count_sat", exc_count, 8'd255);
`endif
    chk("final_idle", 8'(Exc), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
